// File: rtl/periph_interconnect.sv
// Routes core load/store traffic to a stalling data memory or to a set of ready-handshake
// peripheral slots; a peripheral wait ends on ready or after TIMEOUT cycles in PER_WAIT.
module periph_interconnect #(
    parameter int NUM_PERIPH  = 4,
    parameter int MEM_LATENCY = 1,
    parameter int TIMEOUT     = 15
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    wen_i,
    input  logic                    ren_i,
    input  logic [3:0]              stb_i,
    input  logic [31:0]             inst_addr_i,
    input  logic [31:0]             data_addr_i,
    input  logic [31:0]             wdata_i,
    output logic [31:0]             rdata_o,
    output logic                    stall_o,
    output logic                    err_o,
    output logic [31:0]             mem_addr_o,
    output logic                    mem_wen_o,
    output logic [3:0]              mem_stb_o,
    input  logic [31:0]             mem_rdata_i,
    output logic [NUM_PERIPH-1:0]   p_sel_o,
    output logic                    p_wen_o,
    output logic [11:0]             p_addr_o,
    input  logic [32*NUM_PERIPH-1:0] p_rdata_i,
    input  logic [NUM_PERIPH-1:0]   p_ready_i
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        MEM_WAIT = 2'd1,
        PER_WAIT = 2'd2,
        DONE     = 2'd3
    } state_e;

    state_e      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [31:0] rdata_q, rdata_d;
    logic [31:0] addr_q, addr_d;
    logic        err_q, err_d;
    logic        wen_q, wen_d;
    logic [11:0] paddr_q, paddr_d;
    logic [2:0]  idx_q, idx_d;

    logic         req_s;
    logic         is_per_s;
    logic [3:0]   slot_s;
    logic [3:0]   slot_m1_s;
    logic         mapped_s;
    logic [2:0]   idx_s;
    logic [2:0]   cur_idx_s;
    logic [255:0] prd_ext_s;
    logic [7:0]   rdy_ext_s;
    logic [31:0]  slot_rdata_s;
    logic         slot_ready_s;
    logic         unused_s;

    function automatic logic [NUM_PERIPH-1:0] slot_onehot(input logic [2:0] idx);
        logic [7:0] oh;
        oh = 8'd1 << idx;
        return oh[NUM_PERIPH-1:0];
    endfunction

    assign req_s     = wen_i | ren_i;
    assign is_per_s  = data_addr_i[31];
    assign slot_s    = data_addr_i[15:12];
    assign slot_m1_s = slot_s - 4'd1;
    assign mapped_s  = (slot_s != 4'd0) && (slot_s <= 4'(NUM_PERIPH));
    assign idx_s     = slot_m1_s[2:0];
    assign mem_stb_o = stb_i;
    assign unused_s  = ^{data_addr_i[30:16], slot_m1_s[3], wdata_i};

    // Widen the peripheral buses to eight slots and select the addressed one.
    always_comb begin
        prd_ext_s = 256'd0;
        rdy_ext_s = 8'd0;
        prd_ext_s[32*NUM_PERIPH-1:0] = p_rdata_i;
        rdy_ext_s[NUM_PERIPH-1:0]    = p_ready_i;
        cur_idx_s    = (state_q == PER_WAIT) ? idx_q : idx_s;
        slot_rdata_s = prd_ext_s[{cur_idx_s, 5'b00000} +: 32];
        slot_ready_s = rdy_ext_s[cur_idx_s];
    end

    // Next-state and datapath register update.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rdata_d = rdata_q;
        addr_d  = addr_q;
        err_d   = err_q;
        wen_d   = wen_q;
        paddr_d = paddr_q;
        idx_d   = idx_q;
        case (state_q)
            IDLE: begin
                err_d = 1'b0;
                if (!req_s) begin
                    state_d = IDLE;
                end else if (!is_per_s) begin
                    addr_d  = data_addr_i;
                    cnt_d   = 8'(MEM_LATENCY - 1);
                    state_d = MEM_WAIT;
                end else if (!mapped_s) begin
                    rdata_d = 32'd0;
                    err_d   = 1'b1;
                    state_d = DONE;
                end else begin
                    wen_d   = wen_i;
                    paddr_d = data_addr_i[11:0];
                    idx_d   = idx_s;
                    cnt_d   = 8'd0;
                    // Ready already present in the request cycle completes at once.
                    if (slot_ready_s) begin
                        rdata_d = slot_rdata_s;
                        state_d = DONE;
                    end else begin
                        state_d = PER_WAIT;
                    end
                end
            end
            MEM_WAIT: begin
                if (cnt_q == 8'd0) begin
                    rdata_d = mem_rdata_i;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            PER_WAIT: begin
                if (slot_ready_s) begin
                    rdata_d = slot_rdata_s;
                    state_d = DONE;
                end else if (cnt_q == 8'(TIMEOUT - 1)) begin
                    rdata_d = 32'd0;
                    err_d   = 1'b1;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            DONE: begin
                cnt_d   = 8'd0;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Core and bus outputs; reset forces the quiet state regardless of requests.
    always_comb begin
        rdata_o    = 32'd0;
        stall_o    = 1'b0;
        err_o      = 1'b0;
        mem_addr_o = inst_addr_i;
        mem_wen_o  = 1'b0;
        p_sel_o    = '0;
        p_wen_o    = 1'b0;
        p_addr_o   = data_addr_i[11:0];
        if (rst_i) begin
            case (state_q)
                IDLE: begin
                    if (!req_s) begin
                        stall_o = 1'b0;
                    end else if (!is_per_s) begin
                        stall_o    = 1'b1;
                        mem_addr_o = data_addr_i;
                        mem_wen_o  = wen_i;
                    end else if (mapped_s) begin
                        stall_o = 1'b1;
                        p_sel_o = slot_onehot(idx_s);
                        p_wen_o = wen_i;
                    end else begin
                        stall_o = 1'b1;
                    end
                end
                MEM_WAIT: begin
                    stall_o    = 1'b1;
                    mem_addr_o = addr_q;
                end
                PER_WAIT: begin
                    stall_o  = 1'b1;
                    p_sel_o  = slot_onehot(idx_q);
                    p_wen_o  = wen_q;
                    p_addr_o = paddr_q;
                end
                DONE: begin
                    rdata_o = rdata_q;
                    err_o   = err_q;
                end
                default: begin
                    stall_o = 1'b0;
                end
            endcase
        end else begin
            stall_o = 1'b0;
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= IDLE;
            cnt_q   <= 8'd0;
            rdata_q <= 32'd0;
            addr_q  <= 32'd0;
            err_q   <= 1'b0;
            wen_q   <= 1'b0;
            paddr_q <= 12'd0;
            idx_q   <= 3'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            addr_q  <= addr_d;
            err_q   <= err_d;
            wen_q   <= wen_d;
            paddr_q <= paddr_d;
            idx_q   <= idx_d;
        end
    end

endmodule

// File: doc/periph_interconnect.md
PERIPH_INTERCONNECT -- requirements
Module: periph_interconnect

Interface
REQ-001 Parameter NUM_PERIPH, default 4, range 1..8: number of peripheral slots.
REQ-002 Parameter MEM_LATENCY, default 1, range 1..4: cycles of stall per data-memory access.
REQ-003 Parameter TIMEOUT, default 15, range 1..255: maximum cycles to wait for peripheral ready.
REQ-004 Port clk_i, input, 1: single clock; all state updates on rising edge.
REQ-005 Port rst_i, input, 1: reset, asynchronous assert, active-low.
REQ-006 Ports wen_i, ren_i, input, 1 each: core store / load request, held by the core while stall_o=1.
REQ-007 Port stb_i, input, 4: byte strobes, passed unchanged to mem_stb_o.
REQ-008 Ports inst_addr_i, data_addr_i, wdata_i, input, 32 each: fetch address, load/store address, store data.
REQ-009 Ports rdata_o, output, 32 and stall_o, output, 1: load data to the core; core hold request.
REQ-010 Port err_o, output, 1: one-cycle bus-error pulse.
REQ-011 Ports mem_addr_o, output, 32; mem_wen_o, output, 1; mem_stb_o, output, 4; mem_rdata_i, input, 32: memory port.
REQ-012 Ports p_sel_o, output, NUM_PERIPH; p_wen_o, output, 1; p_addr_o, output, 12: peripheral select, write enable, offset (data_addr_i[11:0]).
REQ-013 Ports p_rdata_i, input, 32*NUM_PERIPH (slot k at bits 32k+31:32k); p_ready_i, input, NUM_PERIPH.
REQ-014 Peripheral write data is wdata_i; no separate port.

Function
REQ-015 Request = wen_i | ren_i; wen_i=ren_i=1 is treated as a write.
REQ-016 Target decode: data_addr_i[31]=0 is memory; data_addr_i[31]=1 is peripheral, slot s = data_addr_i[15:12].
REQ-017 Slot s maps to p_sel_o[s-1] for 1<=s<=NUM_PERIPH; s=0 or s>NUM_PERIPH is unmapped.
REQ-018 FSM states: IDLE, MEM_WAIT, PER_WAIT, DONE.
REQ-019 IDLE, no request: stall_o=0, mem_addr_o=inst_addr_i, all selects 0.
REQ-020 IDLE, memory request at cycle T: stall_o=1 combinationally; mem_addr_o=data_addr_i; mem_wen_o=wen_i for cycle T only; next state MEM_WAIT, counter loaded with MEM_LATENCY-1.
REQ-021 MEM_WAIT: stall_o=1; mem_addr_o holds the latched data address; counter decrements; at 0, capture mem_rdata_i into rdata register and go DONE.
REQ-022 Memory access: stall_o high exactly MEM_LATENCY+1 cycles (T..T+MEM_LATENCY); exactly one mem_wen_o pulse per store.
REQ-023 IDLE, mapped peripheral request: stall_o=1; p_sel_o one-hot asserted from cycle T; p_wen_o=wen_i; next state PER_WAIT, timeout counter cleared.
REQ-024 PER_WAIT: select, p_wen_o, p_addr_o held stable; stall_o=1; counter increments each cycle.
REQ-025 p_ready_i of the selected slot high in any cycle from T on: capture that slot's p_rdata_i, drop select next cycle, go DONE.
REQ-026 Counter reaching TIMEOUT without ready: rdata register=0, err flag set, select dropped, go DONE.
REQ-027 IDLE, unmapped peripheral request: no select; rdata register=0; err flag set; go DONE (stall one cycle).
REQ-028 DONE: stall_o=0; rdata_o=captured value; err_o=1 only if err flag set; mem_addr_o=inst_addr_i; the still-present request is ignored; next state IDLE unconditionally.
REQ-029 rdata_o is 0 in every state except DONE.
REQ-030 Ready from a non-selected slot is ignored; ready arriving the cycle after timeout is ignored.

Reset
REQ-031 rst_i=0 forces, asynchronously, state IDLE, counters 0, rdata register 0, err flag 0.
REQ-032 During reset: stall_o, err_o, mem_wen_o, p_wen_o, p_sel_o all 0; mem_addr_o=inst_addr_i.
REQ-033 Reset asserted mid-transaction abandons it with no further mem_wen_o or select; first request after release is decoded fresh from IDLE.

Verification
REQ-034 MEM_LATENCY=2, ren_i at 0x00000100, mem_rdata_i=0xDEADBEEF -> stall_o high 3 cycles, rdata_o=0xDEADBEEF in DONE cycle, err_o=0.
REQ-035 wen_i at 0x00000040, wdata 0x12345678, stb 0xF -> single mem_wen_o pulse with mem_addr_o=0x40, mem_stb_o=0xF.
REQ-036 ren_i at 0x80002004, slot 2 ready after 3 cycles with 0x000000A5 -> p_sel_o=0b0010 held, p_addr_o=0x004, rdata_o=0xA5 in DONE.
REQ-037 TIMEOUT=15, ren_i at 0x80001000, ready never asserted -> select held 15 cycles then dropped, err_o one-cycle pulse, rdata_o=0.
REQ-038 ren_i at 0x80000000 and at 0x80005000 (NUM_PERIPH=4) -> no select, stall_o one cycle, err_o pulse, rdata_o=0.
REQ-039 rst_i low during PER_WAIT -> p_sel_o=0, stall_o=0 immediately; subsequent request completes normally.
